// File: rtl/mod_datapath.sv
// mod_datapath: remainder datapath for the modulo unit.
// Computes A mod B by repeated guarded subtraction under control of the
// CU strobes start / subtract / check_less_than. All outputs are registered.
// Optional feature: define MOD_DP_QUOTIENT_EN to build the subtraction
// counter driving `quotient`; otherwise `quotient` is tied to zero.
module mod_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  input  logic             subtract,
  input  logic             check_less_than,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic             done_r;
  logic             div_zero_r;

  logic [WIDTH-1:0] diff_s;
  logic             step_ok_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] div_nxt_s;
  logic             done_nxt_s;
  logic             div_zero_nxt_s;

  // A step is only legal when it cannot wrap and the divisor is non-zero.
  assign diff_s    = rem_r - div_r;
  assign step_ok_s = (rem_r >= div_r) && (div_r != {WIDTH{1'b0}});

  // Next-state selection with priority start > subtract > check_less_than.
  always_comb begin
    rem_nxt_s      = rem_r;
    div_nxt_s      = div_r;
    done_nxt_s     = done_r;
    div_zero_nxt_s = div_zero_r;
    if (start) begin
      rem_nxt_s = a_in;
      div_nxt_s = b_in;
      if (b_in == {WIDTH{1'b0}}) begin
        div_zero_nxt_s = 1'b1;
        done_nxt_s     = 1'b1;
      end else begin
        div_zero_nxt_s = 1'b0;
        done_nxt_s     = (a_in < b_in);
      end
    end else if (subtract) begin
      if (step_ok_s) begin
        rem_nxt_s  = diff_s;
        // done reflects the remainder being produced on this edge
        done_nxt_s = (diff_s < div_r);
      end else begin
        rem_nxt_s  = rem_r;
      end
    end else if (check_less_than) begin
      done_nxt_s = (rem_r < div_r) | div_zero_r;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r      <= {WIDTH{1'b0}};
      div_r      <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      rem_r      <= rem_nxt_s;
      div_r      <= div_nxt_s;
      done_r     <= done_nxt_s;
      div_zero_r <= div_zero_nxt_s;
    end
  end

  assign done     = done_r;
  assign result   = rem_r;
  assign div_zero = div_zero_r;

`ifdef MOD_DP_QUOTIENT_EN
  logic [WIDTH-1:0] quot_r;
  logic             quot_inc_s;

  // Count only steps that were actually taken (start overrides subtract).
  assign quot_inc_s = !start && subtract && step_ok_s;

  // Subtraction counter, cleared on reset and on every start.
  always_ff @(posedge clk) begin
    if (reset) begin
      quot_r <= {WIDTH{1'b0}};
    end else if (start) begin
      quot_r <= {WIDTH{1'b0}};
    end else if (quot_inc_s) begin
      quot_r <= quot_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      quot_r <= quot_r;
    end
  end

  assign quotient = quot_r;
`else
  assign quotient = {WIDTH{1'b0}};
`endif

endmodule
